// File: rtl/display_source_scheduler.sv
// Picks one of NUM_SOURCES 32-bit debug words for the hex display, advancing on a
// debounced button press or on a timed auto-rotation, with a hold that freezes the view.
module display_source_scheduler #(
  parameter int NUM_SOURCES     = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROTATE_CYCLES   = 50000000,
  parameter int SEL_W           = $clog2(NUM_SOURCES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SOURCES*32-1:0] sources,
  input  logic                      btn_next,
  input  logic                      auto_en,
  input  logic                      hold,
  output logic [31:0]               binary_out,
  output logic [SEL_W-1:0]          sel_idx,
  output logic                      sel_changed
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RCNT_W = $clog2(ROTATE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(ROTATE_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SOURCES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} deb_state_t;

  logic              btn_p0, btn_p1;
  logic              btn_s;
  deb_state_t        state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic              press_evt;
  logic [RCNT_W-1:0] rcnt;
  logic              rot_evt;
  logic              adv;
  logic [31:0]       src_word;

  // Wrap-around successor so sel_idx never reaches an unused code.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (idx == SEL_LAST) ? '0 : idx + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the raw button
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_next;
      btn_p1 <= btn_p0;
    end
  end

  assign btn_s = btn_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    press_evt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = WAIT_PRESS;
          dcnt_nxt  = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (dcnt == DCNT_LAST) begin
          state_nxt = PRESSED;
          press_evt = 1'b1;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = WAIT_RELEASE;
          dcnt_nxt  = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (dcnt == DCNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A press and a rotate tick in the same cycle still collapse into one advance.
  assign rot_evt = auto_en & ~hold & (rcnt == RCNT_LAST);
  assign adv     = (press_evt | rot_evt) & ~hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt <= '0;
    end else if (!auto_en || (press_evt && !hold)) begin
      rcnt <= '0;
    end else if (!hold) begin
      rcnt <= rot_evt ? '0 : rcnt + 1'b1;
    end
  end

  always_comb begin
    src_word = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (sel_idx == SEL_W'(k)) src_word = sources[k*32 +: 32];
    end
  end

  // Stage output: registered selection and displayed word
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_idx     <= '0;
      sel_changed <= 1'b0;
      binary_out  <= '0;
    end else begin
      sel_changed <= adv;
      if (adv) sel_idx <= next_idx(sel_idx);
      if (!hold) binary_out <= src_word;
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a run-length behavioural model.
module tb_display_source_scheduler;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int ROT = 10;

  logic          clock;
  logic          reset;
  logic [N*32-1:0] sources;
  logic          btn_next;
  logic          auto_en;
  logic          hold;
  logic [31:0]   binary_out;
  logic [1:0]    sel_idx;
  logic          sel_changed;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  display_source_scheduler #(
    .NUM_SOURCES    (N),
    .DEBOUNCE_CYCLES(DEB),
    .ROTATE_CYCLES  (ROT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sources    (sources),
    .btn_next   (btn_next),
    .auto_en    (auto_en),
    .hold       (hold),
    .binary_out (binary_out),
    .sel_idx    (sel_idx),
    .sel_changed(sel_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the debounced level flips once the synchronized button has
  // disagreed with it for DEB+1 consecutive cycles; a 0->1 flip is a press.
  int          m_s1, m_s2, m_level, m_run, m_rcnt, m_sel;
  logic [31:0] m_bo;
  logic        m_sc;

  always begin
    bit press, rot, adv;
    @(posedge clock);
    #1;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
      m_rcnt = 0; m_sel = 0; m_bo = '0; m_sc = 1'b0;
    end else begin
      press = 1'b0;
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = m_s2;
          m_run   = 0;
          press   = (m_s2 == 1);
        end
      end else begin
        m_run = 0;
      end
      rot = auto_en && !hold && (m_rcnt == ROT - 1);
      adv = (press || rot) && !hold;
      if (!auto_en || (press && !hold)) m_rcnt = 0;
      else if (!hold) m_rcnt = (m_rcnt + 1) % ROT;
      if (!hold) m_bo = sources[m_sel*32 +: 32];
      m_sc = adv;
      if (adv) m_sel = (m_sel + 1) % N;
      m_s2 = m_s1;
      m_s1 = int'(btn_next);
    end
    check("model_sel_idx", 32'(sel_idx), 32'(m_sel));
    check("model_binary_out", binary_out, m_bo);
    check("model_sel_changed", 32'(sel_changed), 32'(m_sc));
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      pulses += int'(sel_changed);
    end
  endtask

  task automatic press_once();
    btn_next = 1'b1;
    run(10);
    btn_next = 1'b0;
    run(10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev, first;
    int ev_idx[4];
    int ev_sel[4];
    int exp_seq[4] = '{1, 2, 0, 1};
    int btn_left;

    reset    = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    hold     = 1'b0;
    sources  = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

    // Reset state and first visible word
    run(3);
    check("reset_sel_idx", 32'(sel_idx), 32'd0);
    check("reset_binary_out", binary_out, 32'h0);
    reset = 1'b0;
    run(1);
    check("first_word", binary_out, 32'hAAAA_AAAA);

    // Long press gives exactly one advance
    pulses = 0;
    btn_next = 1'b1;
    run(20);
    btn_next = 1'b0;
    run(12);
    check("long_press_pulses", 32'(pulses), 32'd1);
    check("long_press_sel", 32'(sel_idx), 32'd1);
    check("long_press_word", binary_out, 32'hBBBB_BBBB);
    press_once();
    check("wrap_sel_2", 32'(sel_idx), 32'd2);
    press_once();
    check("wrap_sel_0", 32'(sel_idx), 32'd0);

    // Bouncing button shorter than the debounce window
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      btn_next = ~btn_next;
      run(2);
    end
    btn_next = 1'b0;
    run(10);
    check("bounce_pulses", 32'(pulses), 32'd0);
    check("bounce_sel", 32'(sel_idx), 32'd0);

    // Auto rotation every ROT cycles
    auto_en = 1'b1;
    ev = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (sel_changed) begin
        if (ev < 4) begin
          ev_idx[ev] = i;
          ev_sel[ev] = int'(sel_idx);
        end
        ev++;
      end
    end
    check("auto_event_count", 32'(ev), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("auto_event_cycle", 32'(ev_idx[k]), 32'(10 * (k + 1)));
      check("auto_event_sel", 32'(ev_sel[k]), 32'(exp_seq[k]));
    end

    // Press landing on the same cycle as a rotate tick
    auto_en = 1'b0;
    run(1);
    pulses = 0;
    auto_en = 1'b1;
    run(3);
    btn_next = 1'b1;
    run(12);
    auto_en = 1'b0;
    btn_next = 1'b0;
    run(12);
    check("coincident_pulses", 32'(pulses), 32'd1);
    check("coincident_sel", 32'(sel_idx), 32'd2);

    // Hold freezes display and selection
    press_once();
    check("pre_hold_sel", 32'(sel_idx), 32'd0);
    pulses = 0;
    hold = 1'b1;
    sources[31:0] = 32'h1234_5678;
    btn_next = 1'b1;
    auto_en = 1'b1;
    run(10);
    btn_next = 1'b0;
    run(15);
    auto_en = 1'b0;
    run(2);
    check("hold_word", binary_out, 32'hAAAA_AAAA);
    check("hold_sel", 32'(sel_idx), 32'd0);
    check("hold_pulses", 32'(pulses), 32'd0);
    hold = 1'b0;
    run(1);
    check("unhold_word", binary_out, 32'h1234_5678);

    // Reset in the middle of debounce and rotation
    press_once();
    press_once();
    auto_en = 1'b1;
    run(2);
    btn_next = 1'b1;
    run(5);
    check("pre_reset_sel", 32'(sel_idx), 32'd2);
    reset = 1'b1;
    btn_next = 1'b0;
    run(2);
    check("midreset_sel", 32'(sel_idx), 32'd0);
    check("midreset_changed", 32'(sel_changed), 32'd0);
    reset = 1'b0;
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (sel_changed) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("post_reset_first_auto", 32'(first), 32'd10);
    check("post_reset_pulses", 32'(pulses), 32'd1);

    // Button held across reset release yields a single press
    auto_en = 1'b0;
    btn_next = 1'b1;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    pulses = 0;
    run(30);
    check("held_reset_pulses", 32'(pulses), 32'd1);
    check("held_reset_sel", 32'(sel_idx), 32'd1);
    btn_next = 1'b0;
    run(12);

    // Randomized traffic, checked by the model every cycle
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (btn_left == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 7) == 0) sources[$urandom_range(0, N - 1)*32 +: 32] = $urandom;
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
